// File: rtl/y86_arb_pkg.sv
// y86_arb_pkg: shared types and constants for the y86 memory arbiter.
//   state_t  : arbiter FSM states (IDLE, ACCESS, RESP)
//   owner_t  : requester that owns the current access (CORE, DBG)
//   MAX_WAIT : largest supported number of extra memory cycles per access
//   CNT_W    : width of the wait-state counter
package y86_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    CORE = 1'b0,
    DBG  = 1'b1
  } owner_t;

  localparam int unsigned MAX_WAIT = 15;
  localparam int unsigned CNT_W    = 4;

endpackage

// File: rtl/y86_arb_wait_counter.sv
// y86_arb_wait_counter: load/decrement counter that times the memory access phase.
//   clk, rst  : clock, synchronous active-high reset
//   load      : load load_val (has priority over dec)
//   load_val  : value loaded at grant time
//   dec       : decrement by one, saturating at zero
//   zero      : count is zero (last access cycle)
module y86_arb_wait_counter
  import y86_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/y86_mem_arbiter.sv
// y86_mem_arbiter: shares the single y86 memory port between the core and a debug/loader port.
// One access at a time: IDLE (grant) -> ACCESS (WAIT_STATES+1 cycles) -> RESP (ack) -> IDLE.
//   clk, rst                               : clock, synchronous active-high reset
//   core_A/RE/WE/wdata, core_rdata         : core request and returned read data
//   core_ack                               : one-cycle completion pulse to core
//   core_stall                             : core request pending and not yet acked (combinational)
//   dbg_A/RE/WE/wdata, dbg_rdata, dbg_ack  : debug port request, read data, completion pulse
//   mem_A/RE/WE/wdata, mem_rdata           : memory port; mem_A is all-ones when idle
// Optional feature: define Y86_ARB_ROUND_ROBIN_EN to alternate the winner on simultaneous
// requests (the requester that was not last_owner wins); otherwise the core always wins.
module y86_mem_arbiter
  import y86_arb_pkg::*;
#(
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] core_A,
  input  logic          core_RE,
  input  logic          core_WE,
  input  logic [DW-1:0] core_wdata,
  output logic [DW-1:0] core_rdata,
  output logic          core_ack,
  output logic          core_stall,
  input  logic [AW-1:0] dbg_A,
  input  logic          dbg_RE,
  input  logic          dbg_WE,
  input  logic [DW-1:0] dbg_wdata,
  output logic [DW-1:0] dbg_rdata,
  output logic          dbg_ack,
  output logic [AW-1:0] mem_A,
  output logic          mem_RE,
  output logic          mem_WE,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned WAIT_EFF = (WAIT_STATES > MAX_WAIT) ? MAX_WAIT : WAIT_STATES;
`ifdef Y86_ARB_ROUND_ROBIN_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif

  state_t        state, nxt_state;
  owner_t        owner, nxt_owner, last_owner;
  logic          wr, nxt_wr;
  logic [AW-1:0] addr, nxt_addr;
  logic [DW-1:0] wdata, nxt_wdata;
  logic          core_req, dbg_req, core_wins;
  logic          cnt_load, cnt_dec, wait_zero, capture;

  assign core_req = core_RE | core_WE;
  assign dbg_req  = dbg_RE | dbg_WE;

  // Core wins unless only debug requests, or alternation hands the tie to debug
  assign core_wins = core_req & (~dbg_req | ~RR_EN | (last_owner == DBG));

  y86_arb_wait_counter u_wait (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (CNT_W'(WAIT_EFF)),
    .dec      (cnt_dec),
    .zero     (wait_zero)
  );

  // Next-state and grant capture
  always_comb begin
    nxt_state = state;
    nxt_owner = owner;
    nxt_wr    = wr;
    nxt_addr  = addr;
    nxt_wdata = wdata;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    case (state)
      IDLE: begin
        if (core_req | dbg_req) begin
          nxt_state = ACCESS;
          cnt_load  = 1'b1;
          if (core_wins) begin
            nxt_owner = CORE;
            nxt_wr    = core_WE;
            nxt_addr  = core_A;
            nxt_wdata = core_wdata;
          end else begin
            nxt_owner = DBG;
            nxt_wr    = dbg_WE;
            nxt_addr  = dbg_A;
            nxt_wdata = dbg_wdata;
          end
        end
      end
      ACCESS: begin
        cnt_dec = 1'b1;
        if (wait_zero) begin
          nxt_state = RESP;
        end
      end
      RESP:    nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  // FSM and access registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= CORE;
      wr         <= 1'b0;
      addr       <= '0;
      wdata      <= '0;
      last_owner <= DBG;
    end else begin
      state <= nxt_state;
      owner <= nxt_owner;
      wr    <= nxt_wr;
      addr  <= nxt_addr;
      wdata <= nxt_wdata;
      if (state == RESP) begin
        last_owner <= owner;
      end
    end
  end

  // Memory strobes and acks registered from the next state so they align with the state
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_RE    <= 1'b0;
      mem_WE    <= 1'b0;
      mem_A     <= '1;
      mem_wdata <= '0;
      core_ack  <= 1'b0;
      dbg_ack   <= 1'b0;
    end else begin
      mem_RE    <= (nxt_state == ACCESS) & ~nxt_wr;
      mem_WE    <= (nxt_state == ACCESS) & nxt_wr;
      mem_A     <= (nxt_state == ACCESS) ? nxt_addr : '1;
      mem_wdata <= (nxt_state == ACCESS) ? nxt_wdata : '0;
      core_ack  <= (nxt_state == RESP) & (nxt_owner == CORE);
      dbg_ack   <= (nxt_state == RESP) & (nxt_owner == DBG);
    end
  end

  // Read data is valid in the last access cycle
  assign capture = (state == ACCESS) & wait_zero & ~wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      core_rdata <= '0;
      dbg_rdata  <= '0;
    end else if (capture) begin
      if (owner == CORE) begin
        core_rdata <= mem_rdata;
      end else begin
        dbg_rdata <= mem_rdata;
      end
    end
  end

  assign core_stall = core_req & ~core_ack;

endmodule

// File: tb/tb_y86_mem_arbiter.sv
// tb_y86_mem_arbiter: self-checking bench for y86_mem_arbiter.
// u_dut runs with WAIT_STATES=2, u_dut0 with WAIT_STATES=0; both share the request inputs.
// The memory model returns valid read data only in the last access cycle.
module tb_y86_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] core_A, core_wdata, dbg_A, dbg_wdata;
  logic        core_RE, core_WE, dbg_RE, dbg_WE;

  logic [31:0] core_rdata, dbg_rdata, mem_A, mem_wdata, mem_rdata;
  logic        core_ack, core_stall, dbg_ack, mem_RE, mem_WE;

  logic [31:0] z_core_rdata, z_dbg_rdata, z_mem_A, z_mem_wdata, z_mem_rdata;
  logic        z_core_ack, z_core_stall, z_dbg_ack, z_mem_RE, z_mem_WE;

  typedef struct {
    logic        core;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          re_run = 0;
  int          z_re_run = 0;
  logic [31:0] last_core_rd, last_dbg_rd;

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic exp_t mk(input logic core, input logic [31:0] data);
    exp_t e;
    e.core = core;
    e.data = data;
    return e;
  endfunction

  // Count consecutive read-strobe cycles already completed
  always @(posedge clk) begin
    re_run   <= mem_RE ? re_run + 1 : 0;
    z_re_run <= z_mem_RE ? z_re_run + 1 : 0;
  end

  assign mem_rdata   = (mem_RE && re_run == 2) ? rd_model(mem_A) : 32'hBAD0_BAD0;
  assign z_mem_rdata = (z_mem_RE && z_re_run == 0) ? rd_model(z_mem_A) : 32'hBAD0_BAD0;

  y86_mem_arbiter #(.AW(32), .DW(32), .WAIT_STATES(2)) u_dut (
    .clk(clk), .rst(rst),
    .core_A(core_A), .core_RE(core_RE), .core_WE(core_WE), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_ack(core_ack), .core_stall(core_stall),
    .dbg_A(dbg_A), .dbg_RE(dbg_RE), .dbg_WE(dbg_WE), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
    .mem_A(mem_A), .mem_RE(mem_RE), .mem_WE(mem_WE), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  y86_mem_arbiter #(.AW(32), .DW(32), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .core_A(core_A), .core_RE(core_RE), .core_WE(core_WE), .core_wdata(core_wdata),
    .core_rdata(z_core_rdata), .core_ack(z_core_ack), .core_stall(z_core_stall),
    .dbg_A(dbg_A), .dbg_RE(dbg_RE), .dbg_WE(dbg_WE), .dbg_wdata(dbg_wdata),
    .dbg_rdata(z_dbg_rdata), .dbg_ack(z_dbg_ack),
    .mem_A(z_mem_A), .mem_RE(z_mem_RE), .mem_WE(z_mem_WE), .mem_wdata(z_mem_wdata),
    .mem_rdata(z_mem_rdata)
  );

  task automatic test_reset();
    rst = 1'b1;
    core_A = '0; core_RE = 1'b0; core_WE = 1'b0; core_wdata = '0;
    dbg_A = '0; dbg_RE = 1'b0; dbg_WE = 1'b0; dbg_wdata = '0;
    repeat (3) @(negedge clk);
    total++;
    if (mem_RE !== 1'b0 || mem_WE !== 1'b0) begin
      bad++; $display("FAIL reset_strobes got RE=%b WE=%b want 0 0", mem_RE, mem_WE);
    end
    total++;
    if (mem_A !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL reset_mem_A got %h want ffffffff", mem_A);
    end
    total++;
    if (mem_wdata !== 32'h0) begin
      bad++; $display("FAIL reset_mem_wdata got %h want 0", mem_wdata);
    end
    total++;
    if (core_ack !== 1'b0 || dbg_ack !== 1'b0) begin
      bad++; $display("FAIL reset_acks got %b %b want 0 0", core_ack, dbg_ack);
    end
    total++;
    if (core_rdata !== 32'h0 || dbg_rdata !== 32'h0) begin
      bad++; $display("FAIL reset_rdata got %h %h want 0 0", core_rdata, dbg_rdata);
    end
    total++;
    if (core_stall !== 1'b0) begin
      bad++; $display("FAIL reset_stall got %b want 0", core_stall);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_core_read();
    exp_t got;
    core_A = 32'h10; core_RE = 1'b1;
    sb.push_back(mk(1'b1, rd_model(32'h10)));
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      total++;
      if (mem_RE !== (c <= 3) || mem_WE !== 1'b0) begin
        bad++; $display("FAIL rd_strobes c=%0d got RE=%b WE=%b want RE=%b WE=0", c, mem_RE, mem_WE, c <= 3);
      end
      total++;
      if (mem_A !== ((c <= 3) ? 32'h10 : 32'hFFFF_FFFF)) begin
        bad++; $display("FAIL rd_mem_A c=%0d got %h", c, mem_A);
      end
      total++;
      if (core_ack !== (c == 4)) begin
        bad++; $display("FAIL rd_ack c=%0d got %b want %b", c, core_ack, c == 4);
      end
      total++;
      if (core_stall !== (c < 4)) begin
        bad++; $display("FAIL rd_stall c=%0d got %b want %b", c, core_stall, c < 4);
      end
      if (c == 4) begin
        core_RE = 1'b0;
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL rd_sb got empty queue want entry");
        end else begin
          got = sb.pop_front();
          if (core_rdata !== got.data) begin
            bad++; $display("FAIL rd_data got %h want %h", core_rdata, got.data);
          end
          last_core_rd = got.data;
        end
      end
    end
  endtask

  task automatic test_arbitration();
    exp_t got;
    int   acks = 0;
    int   want_c;
    core_A = 32'h30; core_RE = 1'b1;
    dbg_A  = 32'h40; dbg_RE  = 1'b1;
`ifdef Y86_ARB_ROUND_ROBIN_EN
    sb.push_back(mk(1'b0, rd_model(32'h40)));
    sb.push_back(mk(1'b1, rd_model(32'h30)));
`else
    sb.push_back(mk(1'b1, rd_model(32'h30)));
    sb.push_back(mk(1'b0, rd_model(32'h40)));
`endif
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (core_ack || dbg_ack) begin
        acks++;
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL arb_sb got extra ack c=%0d want none", c);
        end else begin
          got = sb.pop_front();
          if (core_ack && dbg_ack) begin
            bad++; $display("FAIL arb_both got two acks c=%0d want one", c);
          end else if (got.core !== core_ack) begin
            bad++; $display("FAIL arb_order got core_ack=%b want %b", core_ack, got.core);
          end else if ((got.core ? core_rdata : dbg_rdata) !== got.data) begin
            bad++; $display("FAIL arb_data got %h want %h", got.core ? core_rdata : dbg_rdata, got.data);
          end
          if (got.core) last_core_rd = got.data;
          else last_dbg_rd = got.data;
        end
        want_c = (acks == 1) ? 4 : 9;
        total++;
        if (c != want_c) begin
          bad++; $display("FAIL arb_latency got cycle %0d want %0d", c, want_c);
        end
        if (core_ack) core_RE = 1'b0;
        if (dbg_ack) dbg_RE = 1'b0;
      end
    end
    total++;
    if (acks != 2) begin
      bad++; $display("FAIL arb_count got %0d acks want 2", acks);
    end
  endtask

  task automatic test_dbg_write();
    exp_t got;
    int   pulses = 0;
    dbg_A = 32'h20; dbg_wdata = 32'hDEAD_BEEF; dbg_WE = 1'b1;
    sb.push_back(mk(1'b0, last_dbg_rd));
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (dbg_ack) pulses++;
      total++;
      if (mem_WE !== (c <= 3) || mem_RE !== 1'b0) begin
        bad++; $display("FAIL wr_strobes c=%0d got WE=%b RE=%b", c, mem_WE, mem_RE);
      end
      if (c <= 3) begin
        total++;
        if (mem_A !== 32'h20 || mem_wdata !== 32'hDEAD_BEEF) begin
          bad++; $display("FAIL wr_bus c=%0d got %h/%h want 00000020/deadbeef", c, mem_A, mem_wdata);
        end
      end
      total++;
      if (dbg_ack !== (c == 4)) begin
        bad++; $display("FAIL wr_ack c=%0d got %b want %b", c, dbg_ack, c == 4);
      end
      total++;
      if (core_stall !== 1'b0) begin
        bad++; $display("FAIL wr_stall c=%0d got %b want 0", c, core_stall);
      end
      if (c == 4) begin
        dbg_WE = 1'b0;
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL wr_sb got empty queue want entry");
        end else begin
          got = sb.pop_front();
          if (dbg_rdata !== got.data) begin
            bad++; $display("FAIL wr_rdata_hold got %h want %h", dbg_rdata, got.data);
          end
        end
      end
    end
    total++;
    if (pulses != 1) begin
      bad++; $display("FAIL wr_pulses got %0d want 1", pulses);
    end
  endtask

  task automatic test_write_wins();
    exp_t got;
    logic re_seen = 1'b0;
    core_A = 32'h50; core_wdata = 32'h1234_5678; core_RE = 1'b1; core_WE = 1'b1;
    sb.push_back(mk(1'b1, last_core_rd));
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      re_seen = re_seen | mem_RE;
      total++;
      if (mem_WE !== (c <= 3)) begin
        bad++; $display("FAIL ww_we c=%0d got %b want %b", c, mem_WE, c <= 3);
      end
      if (c <= 3) begin
        total++;
        if (mem_wdata !== 32'h1234_5678 || mem_A !== 32'h50) begin
          bad++; $display("FAIL ww_bus c=%0d got %h/%h want 00000050/12345678", c, mem_A, mem_wdata);
        end
      end
      if (c == 4) begin
        core_RE = 1'b0; core_WE = 1'b0;
        total++;
        if (core_ack !== 1'b1) begin
          bad++; $display("FAIL ww_ack got %b want 1", core_ack);
        end
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL ww_sb got empty queue want entry");
        end else begin
          got = sb.pop_front();
          if (core_rdata !== got.data) begin
            bad++; $display("FAIL ww_rdata_hold got %h want %h", core_rdata, got.data);
          end
        end
      end
    end
    total++;
    if (re_seen !== 1'b0) begin
      bad++; $display("FAIL ww_no_read got mem_RE seen=%b want 0", re_seen);
    end
  endtask

  task automatic test_reset_mid();
    core_A = 32'h60; core_RE = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      total++;
      if (mem_RE !== 1'b1) begin
        bad++; $display("FAIL rm_access c=%0d got RE=%b want 1", c, mem_RE);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (mem_RE !== 1'b0 || mem_WE !== 1'b0 || mem_A !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL rm_abort got RE=%b WE=%b A=%h want 0 0 ffffffff", mem_RE, mem_WE, mem_A);
    end
    total++;
    if (core_ack !== 1'b0 || core_rdata !== 32'h0) begin
      bad++; $display("FAIL rm_ack got ack=%b rdata=%h want 0 0", core_ack, core_rdata);
    end
    total++;
    if (core_stall !== 1'b1) begin
      bad++; $display("FAIL rm_stall got %b want 1", core_stall);
    end
    rst = 1'b0; core_RE = 1'b0;
    for (int c = 4; c <= 8; c++) begin
      @(negedge clk);
      total++;
      if (core_ack !== 1'b0 || mem_RE !== 1'b0 || mem_A !== 32'hFFFF_FFFF) begin
        bad++; $display("FAIL rm_idle c=%0d got ack=%b RE=%b A=%h", c, core_ack, mem_RE, mem_A);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t got;
    int   n = 1;
    core_A = 32'h100; core_RE = 1'b1;
    sb.push_back(mk(1'b1, rd_model(32'h100)));
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      total++;
      if (z_core_ack !== (c % 3 == 2)) begin
        bad++; $display("FAIL b2b_ack c=%0d got %b want %b", c, z_core_ack, c % 3 == 2);
      end
      total++;
      if (z_core_stall !== ~z_core_ack) begin
        bad++; $display("FAIL b2b_stall c=%0d got %b want %b", c, z_core_stall, ~z_core_ack);
      end
      if (z_core_ack) begin
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL b2b_sb got empty queue want entry c=%0d", c);
        end else begin
          got = sb.pop_front();
          if (z_core_rdata !== got.data) begin
            bad++; $display("FAIL b2b_data c=%0d got %h want %h", c, z_core_rdata, got.data);
          end
        end
        if (n < 4) begin
          core_A = 32'h100 + 32'(4 * n);
          sb.push_back(mk(1'b1, rd_model(core_A)));
          n++;
        end else begin
          core_RE = 1'b0;
        end
      end
    end
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL b2b_left got %0d pending want 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_core_read();
    repeat (2) @(negedge clk);
    test_arbitration();
    repeat (2) @(negedge clk);
    test_dbg_write();
    repeat (2) @(negedge clk);
    test_write_wins();
    repeat (2) @(negedge clk);
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule
